// File: rtl/alu_mc_pkg.sv
// Shared types and helpers for the multi-cycle ALU.
// Optional divider selected by ALU_MC_DIV_EN.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2,
        AND  = 4'd3,
        OR   = 4'd4,
        XOR  = 4'd5,
        SHL  = 4'd6,
        SHR  = 4'd7,
        SAR  = 4'd8,
        MUL  = 4'd9,
        DIVU = 4'd10
    } alu_mc_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alu_mc_state_t;

    // DIVU only runs iteratively when the divider is built; otherwise it decodes as NOP.
    function automatic logic is_multicycle(input alu_mc_op_t op);
        logic mc_s;
        case (op)
            MUL:     mc_s = 1'b1;
`ifdef ALU_MC_DIV_EN
            DIVU:    mc_s = 1'b1;
`endif
            default: mc_s = 1'b0;
        endcase
        return mc_s;
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative datapath: shift-add unsigned multiply and (with ALU_MC_DIV_EN) restoring divide.
// The first step runs on the start edge, so WIDTH steps finish WIDTH-1 edges later.
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_mc_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int SHW = $clog2(WIDTH);

    logic             busy_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic             start_s;
    logic [WIDTH-1:0] cur_acc_s;
    logic [WIDTH-1:0] cur_q_s;
    logic [WIDTH-1:0] cur_m_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] nxt_acc_s;
    logic [WIDTH-1:0] nxt_q_s;
`ifdef ALU_MC_DIV_EN
    logic             div_r;
    logic             cur_div_s;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] diff_s;
`endif

    assign start_s = start && is_multicycle(op);
    assign done    = busy_r && (cnt_r == SHW'(WIDTH - 1));
    assign lo      = nxt_q_s;
    assign hi      = nxt_acc_s;

    // One iteration step; operands come straight from the inputs on the start cycle.
    always_comb begin
        if (start_s) begin
            cur_acc_s = {WIDTH{1'b0}};
            cur_q_s   = a;
            cur_m_s   = b;
`ifdef ALU_MC_DIV_EN
            cur_div_s = (op == DIVU);
            if (op == DIVU) begin
                cur_q_s = b;
                cur_m_s = a;
            end else begin
                cur_q_s = a;
                cur_m_s = b;
            end
`endif
        end else begin
            cur_acc_s = acc_r;
            cur_q_s   = q_r;
            cur_m_s   = m_r;
`ifdef ALU_MC_DIV_EN
            cur_div_s = div_r;
`endif
        end
        sum_s     = {1'b0, cur_acc_s} + {1'b0, (cur_q_s[0] ? cur_m_s : {WIDTH{1'b0}})};
        nxt_acc_s = sum_s[WIDTH:1];
        nxt_q_s   = {sum_s[0], cur_q_s[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // Partial remainder stays below the divisor, so a WIDTH-bit difference is exact.
        rem_s  = {cur_acc_s, cur_q_s[WIDTH-1]};
        diff_s = rem_s[WIDTH-1:0] - cur_m_s;
        if (cur_div_s) begin
            if (rem_s >= {1'b0, cur_m_s}) begin
                nxt_acc_s = diff_s;
                nxt_q_s   = {cur_q_s[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc_s = rem_s[WIDTH-1:0];
                nxt_q_s   = {cur_q_s[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_acc_s = sum_s[WIDTH:1];
            nxt_q_s   = {sum_s[0], cur_q_s[WIDTH-1:1]};
        end
`endif
    end

    // Iteration state and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            cnt_r  <= {SHW{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            q_r    <= {WIDTH{1'b0}};
            m_r    <= {WIDTH{1'b0}};
`ifdef ALU_MC_DIV_EN
            div_r  <= 1'b0;
`endif
        end else if (start_s) begin
            busy_r <= 1'b1;
            cnt_r  <= SHW'(1);
            acc_r  <= nxt_acc_s;
            q_r    <= nxt_q_s;
            m_r    <= cur_m_s;
`ifdef ALU_MC_DIV_EN
            div_r  <= cur_div_s;
`endif
        end else if (busy_r) begin
            busy_r <= !done;
            cnt_r  <= cnt_r + SHW'(1);
            acc_r  <= nxt_acc_s;
            q_r    <= nxt_q_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle datapath, IDLE/BUSY control and result/flag registers.
// Define ALU_MC_DIV_EN to build the DIVU path; otherwise DIVU behaves as NOP.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_mc_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] hi,
    output logic             zf,
    output logic             sf,
    output logic             cf,
    output logic             of
);

    localparam int SHW = $clog2(WIDTH);

    alu_mc_state_t         state_r;
    logic [WIDTH-1:0]      res_r;
    logic [WIDTH-1:0]      hi_r;
    logic                  cf_r;
    logic                  of_r;
    logic                  out_valid_r;
    logic                  accept_s;
    logic                  mc_start_s;
    logic                  sc_wr_s;
    logic [WIDTH-1:0]      sc_res_s;
    logic                  sc_cf_s;
    logic                  sc_of_s;
    logic [SHW-1:0]        amt_s;
    logic [WIDTH:0]        add_s;
    logic [WIDTH:0]        sub_s;
    logic [WIDTH:0]        shl_s;
    logic [WIDTH:0]        shr_s;
    logic signed [WIDTH:0] sar_s;
    logic                  mdu_done_s;
    logic [WIDTH-1:0]      mdu_lo_s;
    logic [WIDTH-1:0]      mdu_hi_s;
`ifdef ALU_MC_DIV_EN
    logic                  op_div_r;
    logic                  a_zero_r;
`endif

    assign in_ready   = (state_r == IDLE);
    assign accept_s   = in_valid && (state_r == IDLE);
    assign mc_start_s = accept_s && is_multicycle(op);
    assign out_valid  = out_valid_r;
    assign res        = res_r;
    assign hi         = hi_r;
    assign cf         = cf_r;
    assign of         = of_r;
    assign zf         = (res_r == {WIDTH{1'b0}});
    assign sf         = res_r[WIDTH-1];

    alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mc_start_s),
        .op    (op),
        .a     (a),
        .b     (b),
        .done  (mdu_done_s),
        .lo    (mdu_lo_s),
        .hi    (mdu_hi_s)
    );

    // Single-cycle results; shifts use a guard bit so the last bit out falls into cf.
    always_comb begin
        amt_s    = a[SHW-1:0];
        add_s    = {1'b0, b} + {1'b0, a};
        sub_s    = {1'b0, b} - {1'b0, a};
        shl_s    = {1'b0, b} << amt_s;
        shr_s    = {b, 1'b0} >> amt_s;
        sar_s    = $signed({b, 1'b0}) >>> amt_s;
        sc_wr_s  = 1'b1;
        sc_res_s = {WIDTH{1'b0}};
        sc_cf_s  = 1'b0;
        sc_of_s  = 1'b0;
        case (op)
            ADD: begin
                sc_res_s = add_s[WIDTH-1:0];
                sc_cf_s  = add_s[WIDTH];
                sc_of_s  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != b[WIDTH-1]);
            end
            SUB: begin
                sc_res_s = sub_s[WIDTH-1:0];
                sc_cf_s  = sub_s[WIDTH];
                sc_of_s  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != b[WIDTH-1]);
            end
            AND: sc_res_s = b & a;
            OR:  sc_res_s = b | a;
            XOR: sc_res_s = b ^ a;
            SHL: begin
                sc_res_s = shl_s[WIDTH-1:0];
                sc_cf_s  = shl_s[WIDTH];
            end
            SHR: begin
                sc_res_s = shr_s[WIDTH:1];
                sc_cf_s  = shr_s[0];
            end
            SAR: begin
                sc_res_s = sar_s[WIDTH:1];
                sc_cf_s  = sar_s[0];
            end
            default: sc_wr_s = 1'b0;
        endcase
    end

    // Control FSM and architectural result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            res_r       <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            cf_r        <= 1'b0;
            of_r        <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef ALU_MC_DIV_EN
            op_div_r    <= 1'b0;
            a_zero_r    <= 1'b0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mc_start_s) begin
                        state_r  <= BUSY;
`ifdef ALU_MC_DIV_EN
                        op_div_r <= (op == DIVU);
                        a_zero_r <= (a == {WIDTH{1'b0}});
`endif
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        if (sc_wr_s) begin
                            res_r <= sc_res_s;
                            hi_r  <= {WIDTH{1'b0}};
                            cf_r  <= sc_cf_s;
                            of_r  <= sc_of_s;
                        end
                    end
                end
                BUSY: begin
                    if (mdu_done_s) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b1;
                        res_r       <= mdu_lo_s;
                        hi_r        <= mdu_hi_s;
`ifdef ALU_MC_DIV_EN
                        if (op_div_r) begin
                            cf_r <= 1'b0;
                            of_r <= a_zero_r;
                        end else begin
                            cf_r <= (mdu_hi_s != {WIDTH{1'b0}});
                            of_r <= (mdu_hi_s != {WIDTH{1'b0}});
                        end
`else
                        cf_r <= (mdu_hi_s != {WIDTH{1'b0}});
                        of_r <= (mdu_hi_s != {WIDTH{1'b0}});
`endif
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
